serial_arithmetic_unit: RTL

Multi-cycle, parametrised successor to the 1-bit arithmetic slice: computes the same four arithmetic functions on WIDTH-bit operands, processing SLICE bits per clock with the carry held in a register between cycles. Sits between the operand register file and the result bus of the datapath. Uses valid/ready handshakes on both sides and produces carry, signed-overflow and zero flags.

---
 rtl/serial_arithmetic_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/serial_arithmetic_unit.sv
// Bit-serial (SLICE bits per clock) adder/subtractor with valid/ready handshakes on both sides.
// Define SAU_FLAGS_EN to build the overflow (v) and zero (z) flag logic; otherwise both read 0.
module serial_arithmetic_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] g,
    output logic             co,
    output logic             v,
    output logic             z
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = $clog2(NSLICE);
    localparam logic [CW-1:0] LastCnt = CW'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0 || NSLICE < 2) begin : g_bad_cfg
        $error("serial_arithmetic_unit: WIDTH must be a multiple of SLICE with NSLICE >= 2");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d, g_q;
    logic [WIDTH-1:0] x_full, y_full;
    logic [1:0]       sel_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, co_q;
    logic [SLICE-1:0] x_sl, y_sl;
    logic [SLICE:0]   sum_sl;
    logic             last, accept;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign accept    = (state_q == StIdle) && in_valid;
    assign last      = (cnt_q == LastCnt);

    // Operand conditioning: the function select only inverts or masks the full-width operands.
    always_comb begin
        x_full = a_q;
        y_full = b_q;
        case (sel_q)
            2'b00:   y_full = '0;
            2'b01:   y_full = b_q;
            2'b10:   y_full = ~b_q;
            default: x_full = ~a_q;
        endcase
    end

    assign x_sl   = x_full[cnt_q*SLICE +: SLICE];
    assign y_sl   = y_full[cnt_q*SLICE +: SLICE];
    assign sum_sl = {1'b0, x_sl} + {1'b0, y_sl} + {{SLICE{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        res_d   = res_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    carry_d = ci;
                end
            end
            StRun: begin
                res_d[cnt_q*SLICE +: SLICE] = sum_sl[SLICE-1:0];
                carry_d = sum_sl[SLICE];
                cnt_d   = cnt_q + CW'(1);
                if (last) state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 2'b00;
            g_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                sel_q <= sel;
            end
            // Visible result only updates on entry to DONE, never mid-operation.
            if (state_q == StRun && last) begin
                g_q  <= res_d;
                co_q <= sum_sl[SLICE];
            end
        end
    end

    assign g  = g_q;
    assign co = co_q;

`ifdef SAU_FLAGS_EN
    logic zacc_q, v_q, z_q;
    logic slice_zero, c_msb;

    assign slice_zero = (sum_sl[SLICE-1:0] == '0);
    // Carry into the top bit recovered from the top bit's own sum.
    assign c_msb      = x_sl[SLICE-1] ^ y_sl[SLICE-1] ^ sum_sl[SLICE-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zacc_q <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
        end else if (accept) begin
            zacc_q <= 1'b1;
        end else if (state_q == StRun) begin
            zacc_q <= zacc_q & slice_zero;
            if (last) begin
                v_q <= c_msb ^ sum_sl[SLICE];
                z_q <= zacc_q & slice_zero;
            end
        end
    end

    assign v = v_q;
    assign z = z_q;
`else
    assign v = 1'b0;
    assign z = 1'b0;
`endif

endmodule
